// File: rtl/fnd_arbiter.sv
// Display arbiter for a 4-digit FND: rotates between three value sources with a
// short source-ID banner on each switch, and pre-empts them with a blinking alert.
module fnd_arbiter #(
  parameter int BANNER_CYC = 50_000_000,
  parameter int ALERT_CYC  = 200_000_000,
  parameter int BLINK_CYC  = 25_000_000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_mode_pedge,
  input  logic [2:0]  req_valid,
  input  logic [15:0] src0_value,
  input  logic [15:0] src1_value,
  input  logic [15:0] src2_value,
  input  logic        alert_req,
  input  logic [15:0] alert_value,
  output logic [15:0] fnd_value,
  output logic [3:0]  blank_mask,
  output logic [2:0]  grant,
  output logic        alert_active
);

  localparam int BW = $clog2(BANNER_CYC + 1);
  localparam int AW = $clog2(ALERT_CYC + 1);
  localparam int KW = $clog2(BLINK_CYC + 1);

  typedef enum logic [1:0] {SHOW, BANNER, ALERT} state_t;

  state_t         state_reg, state_next;
  logic [1:0]     sel_reg, sel_next;
  logic [BW-1:0]  banner_cnt_reg, banner_cnt_next;
  logic [AW-1:0]  alert_cnt_reg, alert_cnt_next;
  logic [KW-1:0]  blink_cnt_reg, blink_cnt_next;
  logic           blink_reg, blink_next;
  logic [15:0]    alert_val_reg, alert_val_next;
  logic           alert_req_reg;

  logic [15:0]    fnd_next;
  logic [3:0]     blank_next;
  logic [2:0]     grant_next;
  logic           active_next;

  logic           alert_edge;
  logic [1:0]     cand1, cand2, next_sel;
  logic           has_next;
  logic [15:0]    src_sel;

  assign alert_edge = alert_req & ~alert_req_reg;

  // Round-robin candidates after the current source: sel+1 first, then sel+2 (mod 3).
  assign cand1    = (sel_reg == 2'd2) ? 2'd0 : sel_reg + 2'd1;
  assign cand2    = (sel_reg == 2'd0) ? 2'd2 : sel_reg - 2'd1;
  assign has_next = req_valid[cand1] | req_valid[cand2];
  assign next_sel = req_valid[cand1] ? cand1 : cand2;

  always_comb begin
    state_next      = state_reg;
    sel_next        = sel_reg;
    banner_cnt_next = banner_cnt_reg;
    alert_cnt_next  = alert_cnt_reg;
    blink_cnt_next  = blink_cnt_reg;
    blink_next      = blink_reg;
    alert_val_next  = alert_val_reg;

    // An alert edge outranks everything, including a simultaneous button press.
    if (alert_edge) begin
      state_next      = ALERT;
      alert_val_next  = alert_value;
      alert_cnt_next  = AW'(ALERT_CYC);
      blink_cnt_next  = KW'(BLINK_CYC);
      blink_next      = 1'b0;
      banner_cnt_next = '0;
    end else begin
      case (state_reg)
        SHOW: begin
          if ((btn_mode_pedge || !req_valid[sel_reg]) && has_next) begin
            state_next      = BANNER;
            sel_next        = next_sel;
            banner_cnt_next = BW'(BANNER_CYC);
          end
        end
        BANNER: begin
          if (btn_mode_pedge && has_next) begin
            sel_next        = next_sel;
            banner_cnt_next = BW'(BANNER_CYC);
          end else if (banner_cnt_reg <= BW'(1)) begin
            state_next      = SHOW;
            banner_cnt_next = '0;
          end else begin
            banner_cnt_next = banner_cnt_reg - BW'(1);
          end
        end
        ALERT: begin
          if (btn_mode_pedge || alert_cnt_reg <= AW'(1)) begin
            state_next     = SHOW;
            alert_cnt_next = '0;
            blink_cnt_next = '0;
            blink_next     = 1'b0;
          end else begin
            alert_cnt_next = alert_cnt_reg - AW'(1);
            if (blink_cnt_reg <= KW'(1)) begin
              blink_next     = ~blink_reg;
              blink_cnt_next = KW'(BLINK_CYC);
            end else begin
              blink_cnt_next = blink_cnt_reg - KW'(1);
            end
          end
        end
        default: state_next = SHOW;
      endcase
    end
  end

  always_comb begin
    case (sel_next)
      2'd0:    src_sel = src0_value;
      2'd1:    src_sel = src1_value;
      default: src_sel = src2_value;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the FSM.
  always_comb begin
    fnd_next    = 16'h0000;
    blank_next  = 4'b1111;
    grant_next  = 3'b000;
    active_next = 1'b0;
    case (state_next)
      SHOW: begin
        if (req_valid[sel_next]) begin
          fnd_next   = src_sel;
          blank_next = 4'b0000;
          grant_next = 3'b001 << sel_next;
        end
      end
      BANNER: begin
        fnd_next   = {14'b0, sel_next};
        blank_next = 4'b1110;
        grant_next = 3'b001 << sel_next;
      end
      ALERT: begin
        fnd_next    = alert_val_next;
        blank_next  = {4{blink_next}};
        active_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_reg      <= SHOW;
      sel_reg        <= 2'd0;
      banner_cnt_reg <= '0;
      alert_cnt_reg  <= '0;
      blink_cnt_reg  <= '0;
      blink_reg      <= 1'b0;
      alert_val_reg  <= 16'h0000;
      alert_req_reg  <= 1'b0;
      fnd_value      <= 16'h0000;
      blank_mask     <= 4'b1111;
      grant          <= 3'b000;
      alert_active   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sel_reg        <= sel_next;
      banner_cnt_reg <= banner_cnt_next;
      alert_cnt_reg  <= alert_cnt_next;
      blink_cnt_reg  <= blink_cnt_next;
      blink_reg      <= blink_next;
      alert_val_reg  <= alert_val_next;
      alert_req_reg  <= alert_req;
      fnd_value      <= fnd_next;
      blank_mask     <= blank_next;
      grant          <= grant_next;
      alert_active   <= active_next;
    end
  end

endmodule

// File: tb/tb_fnd_arbiter.sv
// Directed bench for fnd_arbiter with short timing parameters; expected values
// are hand-derived from the display rules.
module tb_fnd_arbiter;

  logic        clk = 1'b0;
  logic        reset_p;
  logic        btn_mode_pedge;
  logic [2:0]  req_valid;
  logic [15:0] src0_value, src1_value, src2_value;
  logic        alert_req;
  logic [15:0] alert_value;
  logic [15:0] fnd_value;
  logic [3:0]  blank_mask;
  logic [2:0]  grant;
  logic        alert_active;

  int n_checks = 0;
  int n_fail   = 0;

  fnd_arbiter #(.BANNER_CYC(4), .ALERT_CYC(10), .BLINK_CYC(3)) dut (
    .clk(clk), .reset_p(reset_p), .btn_mode_pedge(btn_mode_pedge),
    .req_valid(req_valid), .src0_value(src0_value), .src1_value(src1_value),
    .src2_value(src2_value), .alert_req(alert_req), .alert_value(alert_value),
    .fnd_value(fnd_value), .blank_mask(blank_mask), .grant(grant),
    .alert_active(alert_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] f, input logic [3:0] b,
                            input logic [2:0] g, input logic a);
    $display("%s: fnd=%h blank=%b grant=%b alert=%b", tag, fnd_value, blank_mask, grant, alert_active);
    check({tag, "_fnd"},   32'(fnd_value),    32'(f));
    check({tag, "_blank"}, 32'(blank_mask),   32'(b));
    check({tag, "_grant"}, 32'(grant),        32'(g));
    check({tag, "_alert"}, 32'(alert_active), 32'(a));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_p = 1'b1; btn_mode_pedge = 1'b0; req_valid = 3'b000;
    src0_value = 16'h1234; src1_value = 16'h5678; src2_value = 16'h9ABC;
    alert_req = 1'b0; alert_value = 16'h0000;
    step(); step();
    expect_out("reset", 16'h0000, 4'b1111, 3'b000, 1'b0);

    // Three valid sources: show src0, then press to switch to src1 via banner.
    reset_p = 1'b0; req_valid = 3'b111;
    step();
    expect_out("show0", 16'h1234, 4'b0000, 3'b001, 1'b0);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) step();
      expect_out($sformatf("ban1_c%0d", i), 16'h0001, 4'b1110, 3'b010, 1'b0);
    end
    step();
    expect_out("show1", 16'h5678, 4'b0000, 3'b010, 1'b0);
    src1_value = 16'h1111;
    step();
    expect_out("show1_lat", 16'h1111, 4'b0000, 3'b010, 1'b0);

    // Sources 0 and 2 only: button skips source 1; dropping source 2 auto-advances.
    reset_p = 1'b1; step(); reset_p = 1'b0;
    req_valid = 3'b101;
    step();
    expect_out("skip_show0", 16'h1234, 4'b0000, 3'b001, 1'b0);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    expect_out("skip_ban2", 16'h0002, 4'b1110, 3'b100, 1'b0);
    step(); step(); step(); step();
    expect_out("skip_show2", 16'h9ABC, 4'b0000, 3'b100, 1'b0);
    req_valid = 3'b001;
    step();
    expect_out("auto_ban0", 16'h0000, 4'b1110, 3'b001, 1'b0);
    step(); step(); step(); step();
    expect_out("auto_show0", 16'h1234, 4'b0000, 3'b001, 1'b0);

    // Alert runs for 10 cycles, blinking every 3, then returns to the original source.
    req_valid = 3'b111; alert_value = 16'hBEEF; alert_req = 1'b1;
    step();
    alert_value = 16'h0000;
    for (int i = 1; i <= 10; i++) begin
      if (i > 1) step();
      expect_out($sformatf("alert_c%0d", i), 16'hBEEF,
                 (((i - 1) / 3) % 2 == 1) ? 4'b1111 : 4'b0000, 3'b000, 1'b1);
    end
    step();
    expect_out("alert_timeout", 16'h1234, 4'b0000, 3'b001, 1'b0);

    // Move to source 1, then acknowledge an alert with the button at cycle 4.
    alert_req = 1'b0; btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    step(); step(); step(); step();
    expect_out("pre_ack_show1", 16'h1111, 4'b0000, 3'b010, 1'b0);
    alert_req = 1'b1; alert_value = 16'hCAFE;
    step(); step(); step();
    expect_out("ack_c3", 16'hCAFE, 4'b0000, 3'b000, 1'b1);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    expect_out("ack_show1", 16'h1111, 4'b0000, 3'b010, 1'b0);

    // Alert and button together in SHOW: alert wins, selection stays on source 1.
    alert_req = 1'b0;
    step();
    alert_req = 1'b1; btn_mode_pedge = 1'b1; alert_value = 16'h1357;
    step();
    btn_mode_pedge = 1'b0; alert_req = 1'b0;
    expect_out("both_alert", 16'h1357, 4'b0000, 3'b000, 1'b1);
    step(); step();
    alert_req = 1'b1; alert_value = 16'h2468;
    step();
    expect_out("retrigger", 16'h2468, 4'b0000, 3'b000, 1'b1);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    expect_out("both_show1", 16'h1111, 4'b0000, 3'b010, 1'b0);

    // No valid sources: blanked, button has no effect.
    req_valid = 3'b000;
    step();
    expect_out("none", 16'h0000, 4'b1111, 3'b000, 1'b0);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    expect_out("none_btn", 16'h0000, 4'b1111, 3'b000, 1'b0);

    // Reset in the middle of a banner.
    req_valid = 3'b111; alert_req = 1'b0;
    step();
    expect_out("pre_rst_show1", 16'h1111, 4'b0000, 3'b010, 1'b0);
    btn_mode_pedge = 1'b1;
    step();
    btn_mode_pedge = 1'b0;
    step();
    expect_out("rst_ban_c2", 16'h0002, 4'b1110, 3'b100, 1'b0);
    reset_p = 1'b1;
    step();
    expect_out("rst_ban", 16'h0000, 4'b1111, 3'b000, 1'b0);
    reset_p = 1'b0;
    step();
    expect_out("rst_ban_show0", 16'h1234, 4'b0000, 3'b001, 1'b0);

    // Reset in the middle of an alert.
    alert_req = 1'b1; alert_value = 16'hABCD;
    step(); step(); step(); step(); step();
    expect_out("rst_alert_c5", 16'hABCD, 4'b1111, 3'b000, 1'b1);
    reset_p = 1'b1;
    step();
    expect_out("rst_alert", 16'h0000, 4'b1111, 3'b000, 1'b0);
    reset_p = 1'b0; alert_req = 1'b0;
    step();
    expect_out("rst_alert_show0", 16'h1234, 4'b0000, 3'b001, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
